dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the core's load/store port and a debug/loader port.
//  Sits between the Datapath data-memory interface and the memory macro.
//  The core has default priority; a starvation counter guarantees debug forward progress.
//  Stalls the core whenever it loses arbitration and tags read returns to their owner.
// PARAMETERS
//  DATA_W    32  data word width
//  ADDR_W    9   word address width (512-word memory)
//  MAX_WAIT  4   consecutive denied debug cycles before debug is forced to win (>=1)
// PORTS
//  clk            in   1       clock
//  reset          in   1       asynchronous, active-high reset
//  halt           in   1       core halted; debug gets unconditional priority
//  core_rd        in   1       core load request
//  core_wr        in   1       core store request
//  core_addr      in   ADDR_W  core word address
//  core_wr_data   in   DATA_W  core store data
//  core_stall     out  1       core request not accepted this cycle; core holds request
//  core_rd_valid  out  1       core_rd_data valid (1 cycle after accepted load)
//  core_rd_data   out  DATA_W  load data to core
//  dbg_req        in   1       debug access request
//  dbg_we         in   1       1=write, 0=read (qualified by dbg_req)
//  dbg_addr       in   ADDR_W  debug word address
//  dbg_wr_data    in   DATA_W  debug write data
//  dbg_gnt        out  1       debug request accepted this cycle
//  dbg_rd_valid   out  1       dbg_rd_data valid (1 cycle after accepted read)
//  dbg_rd_data    out  DATA_W  read data to debug
//  mem_rd         out  1       memory read strobe
//  mem_wr         out  1       memory write strobe
//  mem_addr       out  ADDR_W  memory address
//  mem_wr_data    out  DATA_W  memory write data
//  mem_rd_data    in   DATA_W  memory read data (synchronous, valid 1 cycle after mem_rd)
// BEHAVIOUR
//  - Arbitration is per cycle and combinational from inputs plus wait_cnt.
//    core_act = core_rd|core_wr.
//    dbg_win  = dbg_req & (halt | ~core_act | wait_cnt==MAX_WAIT).
//  - Winner drives mem_* in the same cycle. No winner: mem_rd=mem_wr=0, mem_addr/mem_wr_data=0.
//  - Core granted: mem_wr=core_wr; mem_rd=core_rd&~core_wr (store wins if both asserted).
//  - Debug granted: mem_wr=dbg_we; mem_rd=~dbg_we; dbg_gnt=1.
//  - core_stall = core_act & dbg_win. dbg_gnt = dbg_win.
//  - wait_cnt (0..MAX_WAIT, saturating):
//    - increments when dbg_req & ~dbg_win;
//    - clears when dbg_win or ~dbg_req.
//  - Read-return tag register rsp_owner {NONE, CORE, DBG} loads each cycle from that cycle's accepted read.
//    - core_rd_valid = (rsp_owner==CORE); dbg_rd_valid = (rsp_owner==DBG).
//    - Latency: exactly 1 cycle from acceptance to valid.
//  - core_rd_data and dbg_rd_data both carry mem_rd_data. Only the matching valid is meaningful.
//  - Back-to-back accepted reads from alternating owners return in order, one per cycle.
//  - Write-then-read to the same address in consecutive cycles returns the new data (memory is write-first).
//  - halt=1 with core_act=1 still stalls the core while dbg_req=1.
//  - Reset (async):
//    - wait_cnt=0, rsp_owner=NONE, so core_rd_valid=dbg_rd_valid=0.
//    - While reset is high: mem_rd=mem_wr=0, core_stall=0, dbg_gnt=0.
//    - A read accepted in the cycle reset asserts never produces a valid.
//  - Deasserting dbg_req while waiting clears wait_cnt. No request is remembered.
// TESTING
//  1. Reset with all requests high -> mem_rd=mem_wr=0, both rd_valid=0, wait_cnt=0.
//  2. Core store 0xDEADBEEF @0x010, then load @0x010 -> mem_wr one cycle, core_rd_valid next+1 with 0xDEADBEEF, core_stall=0.
//  3. Continuous core loads + dbg_req read @0x1FF -> dbg denied 4 cycles, dbg_gnt and core_stall on 5th, dbg_rd_valid 1 cycle later.
//  4. halt=1, dbg writes 0x00000055 @0x000 every cycle with core_rd held -> dbg_gnt every cycle, core_stall=1 throughout.
//  5. Core_rd and core_wr both high @0x020 -> only mem_wr asserted, no core_rd_valid.
//  6. Assert reset the cycle after an accepted dbg read -> dbg_rd_valid stays 0, wait_cnt=0 after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store port and the debug port.
// The core wins by default. A debug request denied MAX_WAIT cycles in a row, or any debug request while halted, wins instead.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  output logic              core_stall,
  output logic              core_rd_valid,
  output logic [DATA_W-1:0] core_rd_data,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  output logic              dbg_gnt,
  output logic              dbg_rd_valid,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  owner_t           rsp_owner;
  owner_t           rsp_owner_nxt;

  logic core_act;
  logic dbg_win;
  logic core_win;

  // Grants are suppressed while reset is high so nothing reaches the memory during reset.
  assign core_act = core_rd | core_wr;
  assign dbg_win  = ~reset & dbg_req & (halt | ~core_act | (wait_cnt == WAIT_LIMIT));
  assign core_win = ~reset & core_act & ~dbg_win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt  <= '0;
      rsp_owner <= OWN_NONE;
    end else begin
      wait_cnt  <= wait_cnt_nxt;
      rsp_owner <= rsp_owner_nxt;
    end
  end

  always_comb begin
    wait_cnt_nxt  = '0;
    rsp_owner_nxt = OWN_NONE;
    if (dbg_req && !dbg_win) begin
      wait_cnt_nxt = (wait_cnt == WAIT_LIMIT) ? wait_cnt : wait_cnt + 1'b1;
    end
    if (dbg_win && !dbg_we) begin
      rsp_owner_nxt = OWN_DBG;
    end else if (core_win && core_rd && !core_wr) begin
      rsp_owner_nxt = OWN_CORE;
    end
  end

  // A store takes precedence when the core raises load and store together.
  always_comb begin
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (dbg_win) begin
      mem_wr      = dbg_we;
      mem_rd      = ~dbg_we;
      mem_addr    = dbg_addr;
      mem_wr_data = dbg_wr_data;
    end else if (core_win) begin
      mem_wr      = core_wr;
      mem_rd      = core_rd & ~core_wr;
      mem_addr    = core_addr;
      mem_wr_data = core_wr_data;
    end
  end

  always_comb begin
    core_stall    = core_act & dbg_win;
    dbg_gnt       = dbg_win;
    core_rd_valid = (rsp_owner == OWN_CORE);
    dbg_rd_valid  = (rsp_owner == OWN_DBG);
    core_rd_data  = mem_rd_data;
    dbg_rd_data   = mem_rd_data;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a reference model checks every cycle, and a queue of expected read returns checks the read data.
module tb_dmem_arbiter;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 9;
  localparam int MAX_WAIT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              halt;
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wr_data;
  logic              core_stall;
  logic              core_rd_valid;
  logic [DATA_W-1:0] core_rd_data;
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wr_data;
  logic              dbg_gnt;
  logic              dbg_rd_valid;
  logic [DATA_W-1:0] dbg_rd_data;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          owner;
    logic [31:0] data;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [31:0] ref_mem [512];
  logic [31:0] env_mem [512];
  int          m_wait;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .halt(halt),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wr_data(core_wr_data),
    .core_stall(core_stall), .core_rd_valid(core_rd_valid), .core_rd_data(core_rd_data),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_gnt(dbg_gnt), .dbg_rd_valid(dbg_rd_valid), .dbg_rd_data(dbg_rd_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  // Synchronous single-port memory macro standing in for the real one
  always @(posedge clk) begin
    if (mem_wr) env_mem[mem_addr] <= mem_wr_data;
    if (mem_rd) mem_rd_data <= env_mem[mem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model evaluated once per cycle on the falling edge, with inputs stable
  task automatic checkCycle();
    rsp_t        e;
    rsp_t        n;
    bit          core_act, dwin, cwin;
    logic        exp_rd, exp_wr;
    logic [8:0]  exp_addr;
    logic [31:0] exp_wdata;

    e = exp_q.pop_front();
    if (reset) e.owner = 0;
    checkOutput("core_rd_valid", {31'b0, core_rd_valid}, {31'b0, e.owner == 1});
    checkOutput("dbg_rd_valid", {31'b0, dbg_rd_valid}, {31'b0, e.owner == 2});
    if (e.owner == 1) checkOutput("core_rd_data", core_rd_data, e.data);
    if (e.owner == 2) checkOutput("dbg_rd_data", dbg_rd_data, e.data);

    core_act  = core_rd || core_wr;
    dwin      = !reset && dbg_req && (halt || !core_act || m_wait == MAX_WAIT);
    cwin      = !reset && core_act && !dwin;
    exp_rd    = 1'b0;
    exp_wr    = 1'b0;
    exp_addr  = '0;
    exp_wdata = '0;
    n.owner   = 0;
    n.data    = '0;
    if (dwin) begin
      exp_wr = dbg_we; exp_rd = !dbg_we; exp_addr = dbg_addr; exp_wdata = dbg_wr_data;
      if (!dbg_we) n.owner = 2;
    end else if (cwin) begin
      exp_wr = core_wr; exp_rd = core_rd && !core_wr; exp_addr = core_addr; exp_wdata = core_wr_data;
      if (exp_rd) n.owner = 1;
    end
    checkOutput("dbg_gnt", {31'b0, dbg_gnt}, {31'b0, dwin});
    checkOutput("core_stall", {31'b0, core_stall}, {31'b0, core_act && dwin});
    checkOutput("mem_rd", {31'b0, mem_rd}, {31'b0, exp_rd});
    checkOutput("mem_wr", {31'b0, mem_wr}, {31'b0, exp_wr});
    checkOutput("mem_addr", {23'b0, mem_addr}, {23'b0, exp_addr});
    checkOutput("mem_wr_data", mem_wr_data, exp_wdata);

    if (exp_rd) n.data = ref_mem[exp_addr];
    if (exp_wr) ref_mem[exp_addr] = exp_wdata;
    if (reset || !dbg_req || dwin) m_wait = 0;
    else if (m_wait < MAX_WAIT) m_wait++;
    if (reset) exp_q.delete();
    exp_q.push_back(n);
  endtask

  task automatic applyStimulus(input logic rst, input logic h, input logic crd, input logic cwr,
                               input logic [8:0] caddr, input logic [31:0] cdata,
                               input logic dreq, input logic dwe, input logic [8:0] daddr,
                               input logic [31:0] ddata);
    @(posedge clk);
    #1;
    reset = rst; halt = h;
    core_rd = crd; core_wr = cwr; core_addr = caddr; core_wr_data = cdata;
    dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr; dbg_wr_data = ddata;
    @(negedge clk);
    checkCycle();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
  endtask

  initial begin
    rsp_t r0;
    r0.owner = 0;
    r0.data  = '0;
    exp_q.push_back(r0);
    m_wait = 0;
    for (int i = 0; i < 512; i++) begin
      ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
      env_mem[i] <= 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
    end
    reset = 1'b1; halt = 1'b0;
    core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wr_data = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wr_data = '0;

    // Reset with every request raised
    applyStimulus(1, 1, 1, 1, 9'h005, 32'h1111_1111, 1, 0, 9'h006, 32'h2222_2222);
    applyStimulus(1, 1, 1, 1, 9'h005, 32'h1111_1111, 1, 0, 9'h006, 32'h2222_2222);
    checkOutput("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
    checkOutput("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
    checkOutput("rst_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    idleCycle();

    // Core store followed by load to the same word
    applyStimulus(0, 0, 0, 1, 9'h010, 32'hDEAD_BEEF, 0, 0, 9'h0, 32'h0);
    checkOutput("t2_mem_wr", {31'b0, mem_wr}, 32'd1);
    applyStimulus(0, 0, 1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
    checkOutput("t2_stall", {31'b0, core_stall}, 32'd0);
    idleCycle();
    checkOutput("t2_valid", {31'b0, core_rd_valid}, 32'd1);
    checkOutput("t2_data", core_rd_data, 32'hDEAD_BEEF);

    // Debug starved by continuous core loads until the counter saturates
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 9'(i + 32), 32'h0, 1, 0, 9'h1FF, 32'h0);
      checkOutput("t3_gnt", {31'b0, dbg_gnt}, {31'b0, i == 4});
      checkOutput("t3_stall", {31'b0, core_stall}, {31'b0, i == 4});
    end
    applyStimulus(0, 0, 1, 0, 9'h040, 32'h0, 0, 0, 9'h0, 32'h0);
    checkOutput("t3_dbg_valid", {31'b0, dbg_rd_valid}, 32'd1);
    checkOutput("t3_dbg_data", dbg_rd_data, 32'h1FF * 32'h0101_0101 ^ 32'hA5A5_0000);
    idleCycle();

    // Halted core: debug writes win every cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 1, 0, 9'h011, 32'h0, 1, 1, 9'h000, 32'h0000_0055);
      checkOutput("t4_gnt", {31'b0, dbg_gnt}, 32'd1);
      checkOutput("t4_stall", {31'b0, core_stall}, 32'd1);
    end
    idleCycle();

    // Simultaneous load and store from the core
    applyStimulus(0, 0, 1, 1, 9'h020, 32'h1234_5678, 0, 0, 9'h0, 32'h0);
    checkOutput("t5_mem_rd", {31'b0, mem_rd}, 32'd0);
    checkOutput("t5_mem_wr", {31'b0, mem_wr}, 32'd1);
    idleCycle();
    checkOutput("t5_no_valid", {31'b0, core_rd_valid}, 32'd0);

    // Alternating readers, one return per cycle, including the just-written 0x55
    applyStimulus(0, 0, 1, 0, 9'h020, 32'h0, 0, 0, 9'h0, 32'h0);
    applyStimulus(0, 0, 0, 0, 9'h0, 32'h0, 1, 0, 9'h000, 32'h0);
    checkOutput("alt_core_data", core_rd_data, 32'h1234_5678);
    applyStimulus(0, 0, 1, 0, 9'h010, 32'h0, 0, 0, 9'h0, 32'h0);
    checkOutput("alt_dbg_data", dbg_rd_data, 32'h0000_0055);
    idleCycle();

    // Reset right after an accepted debug read, with the counter part-way up
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    applyStimulus(0, 0, 0, 0, 9'h0, 32'h0, 1, 0, 9'h003, 32'h0);
    applyStimulus(1, 0, 0, 0, 9'h0, 32'h0, 0, 0, 9'h0, 32'h0);
    checkOutput("t6_dbg_valid", {31'b0, dbg_rd_valid}, 32'd0);
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    applyStimulus(1, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
      checkOutput("t6_gnt", {31'b0, dbg_gnt}, {31'b0, i == 4});
    end

    // Dropping the request forgets accumulated waiting
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
    applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 0, 0, 9'h002, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 9'h001, 32'h0, 1, 0, 9'h002, 32'h0);
      checkOutput("drop_gnt", {31'b0, dbg_gnt}, {31'b0, i == 4});
    end

    // Random traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                    1'($urandom), $urandom_range(0, 3) == 0, 9'($urandom_range(0, 15)), $urandom,
                    1'($urandom), 1'($urandom), 9'($urandom_range(0, 15)), $urandom);
    end
    idleCycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
